// File: rtl/approx_add_err_monitor.sv
// rtl/approx_add_err_monitor.sv - windowed error statistics for WIDTH-bit approximate adders
// Two-stage pipeline (abs error, then accumulate) under an IDLE/RUN/DRAIN/DONE control FSM.
module approx_add_err_monitor #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  input  logic [WIDTH:0]              in_o,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ack,
  output logic [WIDTH+WIN_LOG2:0]     res_sae,
  output logic [WIDTH:0]              res_mae,
  output logic [WIDTH:0]              res_wce,
  output logic [WIDTH-1:0]            res_wce_a,
  output logic [WIDTH-1:0]            res_wce_b,
  output logic [WIN_LOG2:0]           res_ecnt
);

  localparam int SW = WIDTH + 1 + WIN_LOG2;
  localparam int CW = WIN_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << WIN_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state;

  logic [CW-1:0]    cnt;
  logic             s1_valid, s2_valid;
  logic [WIDTH:0]   s1_d;
  logic [WIDTH-1:0] s1_a, s1_b;

  logic             accept;
  logic [WIDTH:0]   exact;
  logic [WIDTH:0]   abs_err;

  assign accept  = in_valid & in_ready;
  assign exact   = {1'b0, in_a} + {1'b0, in_b};
  // Magnitude of the signed difference; the compare picks the non-negative direction.
  assign abs_err = (exact >= in_o) ? (exact - in_o) : (in_o - exact);
  assign res_mae = res_sae[SW-1:WIN_LOG2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_d      <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      res_sae   <= '0;
      res_wce   <= '0;
      res_wce_a <= '0;
      res_wce_b <= '0;
      res_ecnt  <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) begin
        s1_d <= abs_err;
        s1_a <= in_a;
        s1_b <= in_b;
      end

      // Strict greater-than keeps the earliest sample on ties.
      if (s1_valid) begin
        res_sae <= res_sae + SW'(s1_d);
        if (s1_d != '0)
          res_ecnt <= res_ecnt + CW'(1);
        if (s1_d > res_wce) begin
          res_wce   <= s1_d;
          res_wce_a <= s1_a;
          res_wce_b <= s1_b;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            res_sae   <= '0;
            res_wce   <= '0;
            res_wce_a <= '0;
            res_wce_b <= '0;
            res_ecnt  <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              in_ready <= 1'b0;
              state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!s1_valid && !s2_valid) begin
            busy      <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/approx_add_err_monitor.md
Name: approx_add_err_monitor

Overview:
- Streaming error-characterisation block for approximate unsigned adders (the WIDTH-bit in, WIDTH+1-bit out family).
- Consumes (A, B, O_approx) triples over a valid/ready handshake.
- Recomputes the exact sum and accumulates the following over a window of 2^WIN_LOG2 samples: sum of absolute error, worst-case error with its operands, and error count.
- Sits downstream of the adder under test in the on-FPGA characterisation harness; the host reads the window results over a valid/ack handshake.

Parameters:
- WIDTH, 16, operand width; approximate result is WIDTH+1 bits.
- WIN_LOG2, 10, log2 of window length N (N = 1024 by default); legal range 1..20.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a window when in IDLE, ignored otherwise.
- in_valid  in  1  sample valid.
- in_ready  out  1  monitor can accept a sample.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_o  in  WIDTH+1  approximate sum from the adder under test.
- busy  out  1  high in RUN or DRAIN.
- res_valid  out  1  window results valid.
- res_ack  in  1  host consumed results.
- res_sae  out  WIDTH+1+WIN_LOG2  sum of |exact - in_o| over the window.
- res_mae  out  WIDTH+1  res_sae >> WIN_LOG2, truncated (floor).
- res_wce  out  WIDTH+1  maximum |exact - in_o| in the window.
- res_wce_a  out  WIDTH  in_a of the first sample reaching res_wce.
- res_wce_b  out  WIDTH  in_b of the first sample reaching res_wce.
- res_ecnt  out  WIN_LOG2+1  number of samples with nonzero error.

Behaviour:
- Reset: FSM to IDLE. in_ready=0, busy=0, res_valid=0. All res_* outputs, accumulators, the sample counter and the pipeline valid bits are cleared to 0. Reset mid-window aborts the window; no partial result is ever presented.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 clears accumulators and the counter, then moves to RUN. res_* outputs keep the last window's values until that start.
  - RUN: in_ready=1. A sample is accepted on in_valid & in_ready. The counter increments per accepted sample only; idle or stalled cycles do not count. When the N-th sample is accepted, in_ready drops the next cycle and the FSM moves to DRAIN.
  - DRAIN: in_ready=0. Waits until both pipeline stages are empty (exactly 2 cycles after the last accept), then moves to DONE.
  - DONE: res_valid=1, all res_* outputs stable. res_ack=1 moves to IDLE and clears res_valid the next cycle. res_ack outside DONE is ignored. start in RUN, DRAIN or DONE is ignored.
- Pipeline:
  - Stage 1 (registered at accept): exact = in_a + in_b, zero-extended to WIDTH+1 bits. d = |exact - in_o|, computed in WIDTH+2-bit signed arithmetic and fitting in WIDTH+1 bits. in_a and in_b are carried alongside.
  - Stage 2: sae += d, which cannot overflow because the width is sized for N * (2^(WIDTH+1) - 1). If d != 0, ecnt += 1. If d > wce (strictly greater), wce, wce_a and wce_b are updated, so ties keep the earliest sample.
  - Latency: last accept to res_valid=1 is 3 cycles.
- res_mae is combinational from the res_sae register.
- res_ecnt can equal N (hence WIN_LOG2+1 bits).
- in_o is an arbitrary value. Both the O > exact and O < exact directions are measured. The extreme case O = 2^(WIDTH+1)-1 with A = B = 0 gives d = 131071 at WIDTH=16.
- No samples are accepted outside RUN; in_valid there is back-pressured, not dropped.

Test Plan:
- WIN_LOG2=10, 1024 random samples with in_o = in_a + in_b exact -> res_sae=0, res_mae=0, res_wce=0, res_ecnt=0, res_valid 3 cycles after the 1024th accept.
- WIN_LOG2=10, in_o = exact + 50 on every sample -> res_sae=51200, res_mae=50, res_wce=50, res_ecnt=1024.
- WIN_LOG2=2, samples (A,B,O) = (0,0,0x1FFFF), (1,1,3), (5,5,9), (2,2,5) -> res_wce=131071, res_wce_a=0, res_wce_b=0, res_sae=131074, res_ecnt=4, res_mae=32768.
- WIN_LOG2=2, in_valid toggled every other cycle plus one 5-cycle stall; start pulsed during RUN -> exactly 4 samples counted, start has no effect, results match a golden model.
- WIN_LOG2=2, two samples with error 7 at positions 1 and 3 (A/B differing) -> res_wce=7, res_wce_a/res_wce_b taken from position 1.
- rst asserted after 2 of 4 samples accepted -> FSM in IDLE, res_valid=0, res_* all 0. A fresh start then completes a full window with correct totals. res_valid remains high until res_ack, and res_ack held in IDLE is ignored.
